pa_risc_trace_buffer: RTL and testbench
=======================================

// Module: pa_risc_trace_buffer
// PURPOSE
//   Parametrised hardware trace capture for the PA_RISC pipeline: records write-back
//   retirements as {PC, opcode, RD, PD} into a circular buffer of DEPTH entries.
//   Supports pre/post-trigger capture (PC match, opcode match, immediate, free-run),
//   freeze on trigger plus post_len, and oldest-first readout over a rd_en/rd_valid handshake.
//   Sits beside the WB stage; its taps are wb_* outputs of PA_RISC. Pipeline timing unaffected.
// PARAMETERS
//   PC_W        32  width of captured PC
//   DATA_W      32  width of captured PD (write-back data)
//   DEPTH       16  buffer entries; power of 2, >=2; AW = $clog2(DEPTH)
//   CAPTURE_ALL 0   1: capture every wb_valid retirement; 0: only when wb_rf_le=1
//   REC_W       PC_W+6+5+DATA_W (derived, localparam)
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        async, active-low reset
//   arm        in   1        pulse: clear buffer, sample trig_*/post_len, enter ARMED
//   abort      in   1        pulse: force DONE from ARMED/POST
//   trig_mode  in   2        00 PC match, 01 opcode match, 10 immediate, 11 never (free-run)
//   trig_pc    in   PC_W     PC compare value
//   trig_op    in   6        opcode compare value (Inst[31:26])
//   post_len   in   AW+1     records kept after trigger record; clamped to DEPTH-1
//   wb_valid   in   1        retirement present this cycle
//   wb_rf_le   in   1        register-file write enable of retiring instruction
//   wb_pc      in   PC_W     PC of retiring instruction
//   wb_op      in   6        opcode of retiring instruction
//   wb_rd      in   5        destination register
//   wb_pd      in   DATA_W   write-back data
//   rd_en      in   1        request one record (honoured only in DONE)
//   rd_valid   out  1        rd_rec valid this cycle (single-cycle pulse)
//   rd_rec     out  REC_W    {pc, op, rd, pd}, oldest first
//   state      out  2        00 IDLE, 01 ARMED, 10 POST, 11 DONE
//   count      out  AW+1     records held (0..DEPTH)
//   triggered  out  1        sticky: trigger fired since last arm
//   overflow   out  1        sticky: a write overwrote an entry (count was DEPTH)
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, count=0, wptr=0, rd_valid=0, rd_rec=0,
//     triggered=0, overflow=0; effective immediately, mid-operation included.
//   Capture cond: cap = wb_valid & (wb_rf_le | CAPTURE_ALL), active in ARMED and POST only.
//   Write: mem[wptr]<=record; wptr<=wptr+1 mod DEPTH; count<=min(count+1,DEPTH);
//     overflow<=1 if count==DEPTH at write.
//   ARMED: every cap writes. Match = mode00 wb_pc==trig_pc | mode01 wb_op==trig_op |
//     mode10 any cap | mode11 never. Matching record is stored; triggered<=1;
//     post_len_q==0 -> DONE on same edge, else -> POST with remain<=post_len_q.
//   POST: each cap writes, remain-1; write making remain 0 -> DONE on that edge.
//   DONE: no writes. rd_en & count>0 -> next cycle rd_valid=1, rd_rec=mem[(wptr-count) mod DEPTH],
//     count-1. rd_en & count==0, or rd_en outside DONE -> ignored, rd_valid=0.
//   arm (any state): next edge count=0, wptr=0, triggered=0, overflow=0, rd_valid=0,
//     trig_*/post_len sampled (post_len clamped), state=ARMED. Capture that edge discarded.
//   abort in ARMED/POST -> DONE next edge; cap on same edge still written. No effect in IDLE/DONE.
//   arm & abort same cycle: arm wins.
//   Trig inputs changed after arm: no effect until next arm.
// TESTING
//   1 DEPTH=8, mode00 trig_pc=0x20, post_len=2, PCs 0x04..0x40 step 4 each cycle, rf_le=1 ->
//     DONE after 0x28 stored; count=8, overflow=1, triggered=1; 8 reads return PCs 0x0C..0x28 in order.
//   2 mode01 trig_op=6'b010010 (LDW), post_len=0, ADD,ADD,LDW -> DONE on LDW edge; count=3;
//     last read op=010010; further writes ignored.
//   3 CAPTURE_ALL=0, mode11, 4 retirements, rf_le=1,0,1,0 then abort -> count=2, triggered=0;
//     CAPTURE_ALL=1 same stimulus -> count=4.
//   4 DONE with count=0, rd_en=1 -> rd_valid stays 0, count 0; rd_en in ARMED -> ignored.
//   5 reset low mid-POST (count=5) -> state=00, count=0, rd_valid=0 before next clk edge.
//   6 In DONE count=3, arm&abort same cycle -> state=01, count=0, overflow=0, triggered=0.

Source files
------------

// File: rtl/pa_risc_trace_buffer_if.sv
//------------------------------------------------------------------------------
// Module : pa_risc_trace_buffer_if
// Brief  : Write-back retirement taps and record read-out handshake
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pa_risc_trace_buffer_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);
  localparam int REC_W = PC_W + 6 + 5 + DATA_W;

  logic              wb_valid;
  logic              wb_rf_le;
  logic [PC_W-1:0]   wb_pc;
  logic [5:0]        wb_op;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_pd;
  logic              rd_en;
  logic              rd_valid;
  logic [REC_W-1:0]  rd_rec;

  modport master (
    output wb_valid, wb_rf_le, wb_pc, wb_op, wb_rd, wb_pd, rd_en,
    input  rd_valid, rd_rec
  );

  modport slave (
    input  wb_valid, wb_rf_le, wb_pc, wb_op, wb_rd, wb_pd, rd_en,
    output rd_valid, rd_rec
  );
endinterface

`default_nettype wire

// File: rtl/pa_risc_trace_buffer.sv
//------------------------------------------------------------------------------
// Module : pa_risc_trace_buffer
// Brief  : Circular trace of WB retirements with pre/post-trigger capture
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pa_risc_trace_buffer #(
  parameter  int PC_W        = 32,
  parameter  int DATA_W      = 32,
  parameter  int DEPTH       = 16,
  parameter  int CAPTURE_ALL = 0,
  localparam int AW          = $clog2(DEPTH),
  localparam int REC_W       = PC_W + 6 + 5 + DATA_W
) (
  input  wire logic              clk,
  input  wire logic              reset,
  pa_risc_trace_buffer_if.slave  bus,
  input  wire logic              arm,
  input  wire logic              abort,
  input  wire logic [1:0]        trig_mode,
  input  wire logic [PC_W-1:0]   trig_pc,
  input  wire logic [5:0]        trig_op,
  input  wire logic [AW:0]       post_len,
  output logic [1:0]             state,
  output logic [AW:0]            count,
  output logic                   triggered,
  output logic                   overflow
);

  localparam logic [1:0]  S_IDLE   = 2'b00;
  localparam logic [1:0]  S_ARMED  = 2'b01;
  localparam logic [1:0]  S_POST   = 2'b10;
  localparam logic [1:0]  S_DONE   = 2'b11;
  localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
  localparam logic [AW:0] MAX_POST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic        CAP_ALL  = (CAPTURE_ALL != 0);

  logic [REC_W-1:0]  mem [DEPTH];
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rd_idx;
  logic [AW:0]       remain;
  logic [AW:0]       post_len_q;
  logic [1:0]        mode_q;
  logic [PC_W-1:0]   trig_pc_q;
  logic [5:0]        trig_op_q;
  logic              cap;
  logic              match;
  logic              wr_en;
  logic              rd_go;
  logic              trig_hit;

  assign cap    = bus.wb_valid & (bus.wb_rf_le | CAP_ALL);
  // Oldest entry sits count slots behind wptr; count==DEPTH wraps to wptr itself.
  assign rd_idx = wptr - count[AW-1:0];
  assign state  = state_q;

  always_comb begin
    match = 1'b0;
    case (mode_q)
      2'b00:   match = (bus.wb_pc == trig_pc_q);
      2'b01:   match = (bus.wb_op == trig_op_q);
      2'b10:   match = 1'b1;
      default: match = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = S_ARMED;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (abort || (cap && match && post_len_q == '0)) state_d = S_DONE;
          else if (cap && match)                           state_d = S_POST;
        end
        S_POST: begin
          if (abort || (cap && remain == ONE)) state_d = S_DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // arm overrides everything, so the capture on the arming edge is dropped.
  always_comb begin
    wr_en    = 1'b0;
    rd_go    = 1'b0;
    trig_hit = 1'b0;
    if (!arm) begin
      case (state_q)
        S_ARMED: begin
          wr_en    = cap;
          trig_hit = cap & match;
        end
        S_POST:  wr_en = cap;
        S_DONE:  rd_go = bus.rd_en & (count != '0);
        default: wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= {bus.wb_pc, bus.wb_op, bus.wb_rd, bus.wb_pd};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr         <= '0;
      count        <= '0;
      remain       <= '0;
      post_len_q   <= '0;
      mode_q       <= 2'b11;
      trig_pc_q    <= '0;
      trig_op_q    <= '0;
      triggered    <= 1'b0;
      overflow     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_rec   <= '0;
    end else begin
      bus.rd_valid <= rd_go;
      if (arm) begin
        wptr       <= '0;
        count      <= '0;
        triggered  <= 1'b0;
        overflow   <= 1'b0;
        mode_q     <= trig_mode;
        trig_pc_q  <= trig_pc;
        trig_op_q  <= trig_op;
        post_len_q <= (post_len > MAX_POST) ? MAX_POST : post_len;
      end else begin
        if (wr_en) begin
          wptr <= wptr + AW'(1);
          if (count == FULL) overflow <= 1'b1;
          else               count    <= count + ONE;
          if (state_q == S_POST) remain <= remain - ONE;
        end
        if (trig_hit) begin
          triggered <= 1'b1;
          remain    <= post_len_q;
        end
        if (rd_go) begin
          count      <= count - ONE;
          bus.rd_rec <= mem[rd_idx];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pa_risc_trace_buffer.sv
//------------------------------------------------------------------------------
// Module : tb_pa_risc_trace_buffer
// Brief  : Directed + random bench for the trace buffer, two capture variants
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pa_risc_trace_buffer;
  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int REC_W  = PC_W + 6 + 5 + DATA_W;
  localparam int S_IDLE = 0, S_ARMED = 1, S_POST = 2, S_DONE = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              arm = 1'b0, abort = 1'b0, rd_en = 1'b0;
  logic [1:0]        trig_mode = '0;
  logic [PC_W-1:0]   trig_pc = '0;
  logic [5:0]        trig_op = '0;
  logic [AW:0]       post_len = '0;
  logic              wb_valid = 1'b0, wb_rf_le = 1'b0;
  logic [PC_W-1:0]   wb_pc = '0;
  logic [5:0]        wb_op = '0;
  logic [4:0]        wb_rd = '0;
  logic [DATA_W-1:0] wb_pd = '0;

  logic [1:0]  st0, st1;
  logic [AW:0] cnt0, cnt1;
  logic        trg0, trg1, ovf0, ovf1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pa_risc_trace_buffer_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus0 ();
  pa_risc_trace_buffer_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus1 ();

  assign bus0.wb_valid = wb_valid;  assign bus1.wb_valid = wb_valid;
  assign bus0.wb_rf_le = wb_rf_le;  assign bus1.wb_rf_le = wb_rf_le;
  assign bus0.wb_pc    = wb_pc;     assign bus1.wb_pc    = wb_pc;
  assign bus0.wb_op    = wb_op;     assign bus1.wb_op    = wb_op;
  assign bus0.wb_rd    = wb_rd;     assign bus1.wb_rd    = wb_rd;
  assign bus0.wb_pd    = wb_pd;     assign bus1.wb_pd    = wb_pd;
  assign bus0.rd_en    = rd_en;     assign bus1.rd_en    = rd_en;

  pa_risc_trace_buffer #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CAPTURE_ALL(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_pc(trig_pc), .trig_op(trig_op), .post_len(post_len),
    .state(st0), .count(cnt0), .triggered(trg0), .overflow(ovf0)
  );

  pa_risc_trace_buffer #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CAPTURE_ALL(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_pc(trig_pc), .trig_op(trig_op), .post_len(post_len),
    .state(st1), .count(cnt1), .triggered(trg1), .overflow(ovf1)
  );

  // Reference model: one record queue per DUT, oldest at the front.
  logic [REC_W-1:0] mq [2][$];
  int               mst [2];
  bit               mtrg [2], movf [2], erv [2];
  int               mrem [2], mmode [2], mpost [2];
  logic [PC_W-1:0]  mpc [2];
  logic [5:0]       mop [2];
  logic [REC_W-1:0] erec [2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mst[k] = S_IDLE; mtrg[k] = 0; movf[k] = 0; erv[k] = 0; mrem[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit cp, hit;
    logic [REC_W-1:0] r;
    cp = wb_valid && (wb_rf_le || k == 1);
    r  = {wb_pc, wb_op, wb_rd, wb_pd};
    erv[k] = 0;
    if (arm) begin
      mq[k].delete();
      mtrg[k] = 0; movf[k] = 0; mst[k] = S_ARMED;
      mmode[k] = int'(trig_mode); mpc[k] = trig_pc; mop[k] = trig_op;
      mpost[k] = (int'(post_len) > DEPTH - 1) ? DEPTH - 1 : int'(post_len);
      return;
    end
    if (mst[k] == S_ARMED || mst[k] == S_POST) begin
      if (cp) begin
        if (mq[k].size() == DEPTH) begin
          movf[k] = 1;
          void'(mq[k].pop_front());
        end
        mq[k].push_back(r);
      end
      if (mst[k] == S_ARMED) begin
        hit = cp && ((mmode[k] == 0 && wb_pc == mpc[k]) ||
                     (mmode[k] == 1 && wb_op == mop[k]) || mmode[k] == 2);
        if (hit) mtrg[k] = 1;
        if (abort) mst[k] = S_DONE;
        else if (hit) begin
          mrem[k] = mpost[k];
          mst[k]  = (mpost[k] == 0) ? S_DONE : S_POST;
        end
      end else begin
        if (cp) mrem[k]--;
        if (abort || (cp && mrem[k] == 0)) mst[k] = S_DONE;
      end
    end else if (mst[k] == S_DONE && rd_en && mq[k].size() > 0) begin
      erec[k] = mq[k].pop_front();
      erv[k]  = 1;
    end
  endtask

  task automatic cmp_one(input int k, input logic [1:0] st, input logic [AW:0] cnt,
                         input logic trg, input logic ovf, input logic rv,
                         input logic [REC_W-1:0] rr);
    check($sformatf("state%0d", k), st, mst[k]);
    check($sformatf("count%0d", k), cnt, mq[k].size());
    check($sformatf("triggered%0d", k), trg, mtrg[k]);
    check($sformatf("overflow%0d", k), ovf, movf[k]);
    check($sformatf("rd_valid%0d", k), rv, erv[k]);
    if (erv[k]) check($sformatf("rd_rec%0d", k), rr, erec[k]);
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    cmp_one(0, st0, cnt0, trg0, ovf0, bus0.rd_valid, bus0.rd_rec);
    cmp_one(1, st1, cnt1, trg1, ovf1, bus1.rd_valid, bus1.rd_rec);
    @(negedge clk);
    arm = 0; abort = 0; rd_en = 0; wb_valid = 0;
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [PC_W-1:0] pc,
                        input logic [5:0] op, input logic [AW:0] plen);
    arm = 1; trig_mode = mode; trig_pc = pc; trig_op = op; post_len = plen;
    cycle();
  endtask

  task automatic retire(input logic [PC_W-1:0] pc, input logic [5:0] op, input logic le);
    wb_valid = 1; wb_rf_le = le; wb_pc = pc; wb_op = op;
    wb_rd = 5'($urandom); wb_pd = $urandom;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_model();
    @(negedge clk); @(negedge clk);
    check("rst_state", st0, 2'b00);
    check("rst_count", cnt0, 0);
    check("rst_rd_valid", bus0.rd_valid, 0);
    check("rst_rd_rec", bus0.rd_rec, 0);
    check("rst_flags", {trg0, ovf0, trg1, ovf1}, 4'b0000);
    reset = 1;
    @(negedge clk);

    // PC-match trigger with post-trigger window and wraparound
    do_arm(2'b00, 32'h20, 6'h00, 4'd2);
    for (int i = 1; i <= 16; i++) retire(32'(4 * i), 6'h01, 1'b1);
    check("t1_state", st0, 2'b11);
    check("t1_count", cnt0, 8);
    check("t1_flags", {trg0, ovf0}, 2'b11);
    for (int i = 0; i < 8; i++) begin
      rd_en = 1;
      cycle();
      check("t1_rd_pc", bus0.rd_rec[REC_W-1 -: PC_W], 32'h0C + 32'(4 * i));
    end

    // Opcode-match trigger, zero post length
    do_arm(2'b01, 32'h0, 6'b010010, 4'd0);
    retire(32'h100, 6'b000010, 1'b1);
    retire(32'h104, 6'b000010, 1'b1);
    retire(32'h108, 6'b010010, 1'b1);
    check("t2_state", st0, 2'b11);
    retire(32'h10C, 6'b010010, 1'b1);
    retire(32'h110, 6'b000010, 1'b1);
    check("t2_count", cnt0, 3);
    for (int i = 0; i < 3; i++) begin rd_en = 1; cycle(); end
    check("t2_last_op", bus0.rd_rec[DATA_W+5 +: 6], 6'b010010);

    // Free-run, rf_le gating, abort
    do_arm(2'b11, 32'h0, 6'h00, 4'd0);
    retire(32'h200, 6'h01, 1'b1);
    retire(32'h204, 6'h01, 1'b0);
    retire(32'h208, 6'h01, 1'b1);
    retire(32'h20C, 6'h01, 1'b0);
    abort = 1;
    cycle();
    check("t3_count_cap0", cnt0, 2);
    check("t3_count_cap1", cnt1, 4);
    check("t3_triggered", trg0, 0);

    // Reads on empty buffer and outside DONE
    for (int i = 0; i < 5; i++) begin rd_en = 1; cycle(); end
    rd_en = 1;
    cycle();
    check("t4_empty_rv", bus0.rd_valid, 0);
    check("t4_empty_cnt", cnt0, 0);
    do_arm(2'b11, 32'h0, 6'h00, 4'd0);
    rd_en = 1;
    cycle();
    check("t4_armed_rv", bus0.rd_valid, 0);

    // Async reset mid-POST
    do_arm(2'b10, 32'h0, 6'h00, 4'd7);
    for (int i = 0; i < 5; i++) retire(32'(32'h300 + 4 * i), 6'h01, 1'b1);
    check("t5_pre_state", st0, 2'b10);
    check("t5_pre_count", cnt0, 5);
    reset = 0;
    #1;
    check("t5_state", st0, 2'b00);
    check("t5_count", cnt0, 0);
    check("t5_rd_valid", bus0.rd_valid, 0);
    reset_model();
    @(negedge clk);
    reset = 1;

    // arm and abort together from DONE
    do_arm(2'b10, 32'h0, 6'h00, 4'd2);
    for (int i = 0; i < 3; i++) retire(32'(32'h400 + 4 * i), 6'h01, 1'b1);
    check("t6_pre_count", cnt0, 3);
    arm = 1; abort = 1; trig_mode = 2'b11; post_len = '0;
    cycle();
    check("t6_state", st0, 2'b01);
    check("t6_count", cnt0, 0);
    check("t6_flags", {trg0, ovf0}, 2'b00);

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      do_arm(2'($urandom_range(0, 3)), 32'($urandom_range(0, 15) * 4),
             6'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      for (int c = 0; c < 60; c++) begin
        wb_valid  = ($urandom_range(0, 9) < 7);
        wb_rf_le  = 1'($urandom_range(0, 1));
        wb_pc     = 32'($urandom_range(0, 15) * 4);
        wb_op     = 6'($urandom_range(0, 3));
        wb_rd     = 5'($urandom);
        wb_pd     = $urandom;
        abort     = ($urandom_range(0, 49) == 0);
        rd_en     = ($urandom_range(0, 2) == 0);
        arm       = ($urandom_range(0, 99) == 0);
        trig_mode = 2'($urandom_range(0, 3));
        trig_pc   = 32'($urandom_range(0, 15) * 4);
        trig_op   = 6'($urandom_range(0, 3));
        post_len  = 4'($urandom_range(0, 15));
        cycle();
      end
      abort = 1;
      cycle();
      for (int c = 0; c < DEPTH + 2; c++) begin rd_en = 1; cycle(); end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
